fifo_sc_prog_m: RTL

Single-clock, pure-RTL FIFO. It replaces the vendor-macro FIFO wrapper wherever portability, a selectable read mode or programmable flags are needed. It provides:
- FWFT or standard read mode
- programmable almost-full/almost-empty thresholds
- registered occupancy count
- synchronous flush
- sticky overflow/underflow error flags

It sits between producer/consumer pipeline stages inside one clock domain.

---
 rtl/fifo_sc_prog_m.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/fifo_sc_prog_m.sv
// Single-clock FIFO with FWFT/standard read mode, programmable almost flags, occupancy count, flush and sticky errors.
// Latency: a push is visible on head one edge later (FWFT); standard mode presents data the cycle after pop.
// Backpressure: push while full is dropped and sets overflow; pop while empty is ignored and sets underflow.
module fifo_sc_prog_m #(
    parameter type DATA_ITEM_TYPE = logic,
    parameter int  DEPTH          = 32,
    parameter bit  FWFT           = 1'b1,
    parameter int  AFULL_THRESH   = DEPTH - 2,
    parameter int  AEMPTY_THRESH  = 2,
    // Set to 0 where pushes into a full / pops from an empty FIFO are intentional.
    parameter bit  ASSERT_EN      = 1'b1,
    localparam int DATA_COUNT_W   = $clog2(DEPTH) + 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [$bits(DATA_ITEM_TYPE)-1:0]  tail,
    input  logic                              push,
    input  logic                              pop,
    input  logic                              flush,
    input  logic                              err_clr,
    output logic [$bits(DATA_ITEM_TYPE)-1:0]  head,
    output logic                              full,
    output logic                              empty,
    output logic                              almost_full,
    output logic                              almost_empty,
    output logic [DATA_COUNT_W-1:0]           data_count,
    output logic                              overflow,
    output logic                              underflow
);

    localparam int W  = $bits(DATA_ITEM_TYPE);
    localparam int AW = $clog2(DEPTH);

    localparam logic [DATA_COUNT_W-1:0] CNT_ONE   = DATA_COUNT_W'(1);
    localparam logic [DATA_COUNT_W-1:0] CNT_DEPTH = DATA_COUNT_W'(DEPTH);
    localparam logic [DATA_COUNT_W-1:0] AF_T      = DATA_COUNT_W'(AFULL_THRESH);
    localparam logic [DATA_COUNT_W-1:0] AE_T      = DATA_COUNT_W'(AEMPTY_THRESH);
    localparam logic [AW-1:0]           PTR_ONE   = AW'(1);

    // Parameter sanity, caught at elaboration.
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("fifo_sc_prog_m: DEPTH must be a power of two >= 2");
    end
    if (AFULL_THRESH < 1 || AFULL_THRESH > DEPTH) begin : g_bad_afull
        $error("fifo_sc_prog_m: AFULL_THRESH must be in 1..DEPTH");
    end
    if (AEMPTY_THRESH < 0 || AEMPTY_THRESH > DEPTH - 1) begin : g_bad_aempty
        $error("fifo_sc_prog_m: AEMPTY_THRESH must be in 0..DEPTH-1");
    end

    logic [W-1:0]              mem [DEPTH];
    logic [AW-1:0]             wr_ptr;
    logic [AW-1:0]             rd_ptr;
    logic [DATA_COUNT_W-1:0]   count_q;
    logic [DATA_COUNT_W-1:0]   count_nxt;
    logic                      full_q;
    logic                      empty_q;
    logic                      afull_q;
    logic                      aempty_q;
    logic                      ovf_q;
    logic                      udf_q;
    logic                      pop_acc;
    logic                      wr_acc;
    logic                      ovf_set;
    logic                      udf_set;

    // Accept decisions, error events and next occupancy; flush overrides push/pop.
    always_comb begin
        pop_acc   = 1'b0;
        wr_acc    = 1'b0;
        ovf_set   = 1'b0;
        udf_set   = 1'b0;
        count_nxt = count_q;
        if (flush) begin
            count_nxt = '0;
        end else begin
            pop_acc = pop && !empty_q;
            // A pop in the same cycle frees the slot, so a full FIFO still takes the push.
            wr_acc  = push && (!full_q || pop_acc);
            ovf_set = push && !wr_acc;
            udf_set = pop && !pop_acc;
            case ({wr_acc, pop_acc})
                2'b10:   count_nxt = count_q + CNT_ONE;
                2'b01:   count_nxt = count_q - CNT_ONE;
                default: count_nxt = count_q;
            endcase
        end
    end

    // Pointers, count and status flags; flags derive from the next count so they always agree with data_count.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
        end else begin
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (wr_acc)  wr_ptr <= wr_ptr + PTR_ONE;
                if (pop_acc) rd_ptr <= rd_ptr + PTR_ONE;
            end
            count_q  <= count_nxt;
            full_q   <= (count_nxt == CNT_DEPTH);
            empty_q  <= (count_nxt == '0);
            afull_q  <= (count_nxt >= AF_T);
            aempty_q <= (count_nxt <= AE_T);
        end
    end

    // Sticky error flags: a new event beats err_clr; flush leaves them alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            if (ovf_set)      ovf_q <= 1'b1;
            else if (err_clr) ovf_q <= 1'b0;
            if (udf_set)      udf_q <= 1'b1;
            else if (err_clr) udf_q <= 1'b0;
        end
    end

    // Storage array; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (!rst && wr_acc) begin
            mem[wr_ptr] <= tail;
        end
    end

    if (FWFT) begin : g_fwft
        // Head falls straight through from the read pointer; forced to zero while nothing is valid.
        assign head = empty_q ? '0 : mem[rd_ptr];
    end else begin : g_std
        logic [W-1:0] head_q;
        // Head register loads the oldest entry on an accepted pop and holds otherwise.
        always_ff @(posedge clk) begin
            if (rst || flush) begin
                head_q <= '0;
            end else if (pop_acc) begin
                head_q <= mem[rd_ptr];
            end
        end
        assign head = head_q;
    end

    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = afull_q;
    assign almost_empty = aempty_q;
    assign data_count   = count_q;
    assign overflow     = ovf_q;
    assign underflow    = udf_q;

    if (ASSERT_EN) begin : g_chk
        a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && full && !pop))
            else $error("fifo_sc_prog_m: push while full");
        a_no_underflow: assert property (@(posedge clk) disable iff (rst) !(pop && empty))
            else $error("fifo_sc_prog_m: pop while empty");
    end

endmodule
